// File: rtl/ct_spsram_4096x128_ctrl.sv
// ---------------------------------------------------------------------------
// ct_spsram_4096x128_ctrl
//
// Initiator-side controller for the 4096x128 single-port SRAM wrapper.
// Turns a valid/ready request stream into the SRAM's active-low
// CEN/GWEN/WEN protocol. Read data is captured one cycle after the access
// and returned through a 2-entry response FIFO. After reset the whole
// array is optionally zero-filled before requests are accepted.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   req_vld/req_rdy     request handshake
//   req_wr              1 = write, 0 = read
//   req_addr            word address
//   req_wdata, req_be   write data and active-high byte enables
//   rsp_vld/rsp_rdy     read response handshake
//   rsp_rdata           read response data (head of the response FIFO)
//   init_done           array fill complete, port usable
//   A, CEN, GWEN, WEN, D  SRAM address / controls (active-low) / write data
//   Q                   SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module ct_spsram_4096x128_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    parameter int BE_WIDTH   = 16,
    parameter int RSP_DEPTH  = 2,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;

    // Reset dominates combinationally so the reset cycle itself shows the
    // idle drive and no handshakes, whatever state was left behind.
    logic w_run;
    logic w_init;
    logic w_acc;
    logic w_push;
    logic w_pop;
    logic [2:0] w_occ;
    logic [2:0] w_occ_nxt;

    logic                  r_rd_inflight_p1;
    logic [DATA_WIDTH-1:0] r_fifo_mem [RSP_DEPTH];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    assign w_run  = (r_state == ST_RUN)  & ~RST;
    assign w_init = (r_state == ST_INIT) & ~RST;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= INIT_EN ? ST_INIT : ST_RUN;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_INIT) && (r_init_cnt == {ADDR_WIDTH{1'b1}})) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Credit check counts the read still in flight to the FIFO, and lets a
    // same-cycle pop free a slot (intentional rsp_rdy -> req_rdy path).
    assign w_pop     = rsp_vld & rsp_rdy;
    assign w_push    = r_rd_inflight_p1;
    assign w_occ     = {1'b0, r_count} + {2'b00, r_rd_inflight_p1};
    assign w_occ_nxt = w_occ - {2'b00, w_pop};
    assign req_rdy   = w_run & (w_occ_nxt < 3'(RSP_DEPTH));
    assign w_acc     = req_vld & req_rdy;
    assign init_done = w_run;

    // ---------------- FSM: outputs / SRAM drive ----------------
    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        A    = '0;
        D    = '0;
        if (w_init) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = r_init_cnt;
        end else if (w_run) begin
            CEN  = ~w_acc;
            GWEN = ~(w_acc & req_wr);
            A    = req_addr;
            D    = req_wdata;
            if (w_acc && req_wr) begin
                for (int k = 0; k < BE_WIDTH; k++) begin
                    WEN[8*k +: 8] = {8{~req_be[k]}};
                end
            end
        end
    end

    // ---------------- Stage p1: read in flight, Q capture ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_inflight_p1 <= 1'b0;
            r_wptr           <= 1'b0;
            r_rptr           <= 1'b0;
            r_count          <= 2'd0;
        end else begin
            r_rd_inflight_p1 <= w_acc & ~req_wr;
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= Q;
        end
    end

    // ---------------- Stage p2: response head ----------------
    assign rsp_vld   = (r_count != 2'd0) & ~RST;
    assign rsp_rdata = rsp_vld ? r_fifo_mem[r_rptr] : '0;

    // The credit rule must make a push into a full FIFO without a pop impossible.
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(w_push && !w_pop && (r_count == 2'(RSP_DEPTH))));

endmodule
